// File: rtl/fetch_realign_pkg.sv
// Shared frontend fetch geometry and the RVC length test used when walking parcels.
package fetch_realign_pkg;

  localparam int unsigned FETCH_WIDTH     = 64;
  localparam int unsigned INSTR_PER_FETCH = FETCH_WIDTH / 16;

  // Any opcode whose two low bits are not 2'b11 is a 16-bit compressed instruction.
  function automatic logic is_rvc(input logic [1:0] op);
    return op != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_realign_rvc_parcel_decode.sv
// Combinational parcel walker: splits one fetch packet into instruction slots and
// reports a trailing 32-bit instruction whose upper half lies in the next packet.
module rvc_parcel_decode #(
  parameter int unsigned FETCH_WIDTH = 64,
  localparam int unsigned N  = FETCH_WIDTH / 16,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic                        data_valid_i,
  input  logic                        exception_i,
  input  logic [FETCH_WIDTH-1:0]      data_i,
  input  logic [63:0]                 addr_i,
  input  logic [PW-1:0]               start_i,
  input  logic                        cont_i,
  input  logic [15:0]                 upper_q_i,
  input  logic [63:0]                 upper_addr_i,
  output logic [N-1:0][31:0]          instr_o,
  output logic [N-1:0][63:0]          addr_o,
  output logic [N-1:0]                valid_o,
  output logic                        straddle_o,
  output logic [15:0]                 straddle_parcel_o,
  output logic [63:0]                 straddle_addr_o
);
  import fetch_realign_pkg::*;

  localparam int OFF = PW + 1;
  localparam int NI  = int'(N);

  // One zero parcel of padding keeps the p+1 lookup in range for the last parcel.
  logic [FETCH_WIDTH+15:0] data_x;
  logic [PW-1:0]           slot;
  logic                    skip;
  logic [15:0]             parcel;
  logic [63:0]             pc;

  assign data_x = {16'b0, data_i};

  always_comb begin
    instr_o           = '0;
    addr_o            = '0;
    valid_o           = '0;
    straddle_o        = 1'b0;
    straddle_parcel_o = '0;
    straddle_addr_o   = '0;
    slot              = '0;
    skip              = 1'b0;
    parcel            = '0;
    pc                = '0;
    if (data_valid_i && exception_i) begin
      valid_o[0] = 1'b1;
      addr_o[0]  = addr_i;
    end else if (data_valid_i) begin
      if (cont_i) begin
        instr_o[0] = {data_i[15:0], upper_q_i};
        addr_o[0]  = upper_addr_i;
        valid_o[0] = 1'b1;
        slot       = PW'(1);
        skip       = 1'b1;
      end
      for (int p = 0; p < NI; p++) begin
        parcel = data_x[16*p +: 16];
        pc     = {addr_i[63:OFF], p[PW-1:0], 1'b0};
        if (skip) begin
          skip = 1'b0;
        end else if (p >= int'(start_i)) begin
          if (is_rvc(parcel[1:0])) begin
            instr_o[slot] = {16'b0, parcel};
            addr_o[slot]  = pc;
            valid_o[slot] = 1'b1;
            slot          = slot + 1'b1;
          end else if (p < NI - 1) begin
            instr_o[slot] = {data_x[16*(p+1) +: 16], parcel};
            addr_o[slot]  = pc;
            valid_o[slot] = 1'b1;
            slot          = slot + 1'b1;
            skip          = 1'b1;
          end else begin
            straddle_o        = 1'b1;
            straddle_parcel_o = parcel;
            straddle_addr_o   = pc;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fetch_realign.sv
// Fetch packet realigner: holds the lower half of a straddling 32-bit instruction
// across packets and presents parsed slots to the instruction queue.
module fetch_realign #(
  parameter int unsigned FETCH_WIDTH = fetch_realign_pkg::FETCH_WIDTH,
  localparam int unsigned INSTR_PER_FETCH = FETCH_WIDTH / 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic                              replay_i,
  input  logic                              data_valid_i,
  input  logic [FETCH_WIDTH-1:0]            data_i,
  input  logic [63:0]                       addr_i,
  input  logic                              exception_i,
  input  logic                              ready_i,
  output logic                              ready_o,
  output logic [INSTR_PER_FETCH-1:0][31:0]  instr_o,
  output logic [INSTR_PER_FETCH-1:0][63:0]  addr_o,
  output logic [INSTR_PER_FETCH-1:0]        valid_o,
  output logic                              exception_o
);
  import fetch_realign_pkg::*;

  localparam int unsigned PW  = $clog2(INSTR_PER_FETCH);
  localparam int unsigned OFF = PW + 1;

  logic          has_upper;
  logic [15:0]   upper_q;
  logic [63:0]   upper_addr_q;
  logic [PW-1:0] start;
  logic          cont;
  logic          accept;
  logic          straddle;
  logic [15:0]   straddle_parcel;
  logic [63:0]   straddle_addr;

  assign start       = addr_i[OFF-1:1];
  // A stored half only joins a packet that resumes exactly after it.
  assign cont        = has_upper && (start == '0) && (addr_i == upper_addr_q + 64'd2);
  assign accept      = data_valid_i && ready_i && !replay_i && !flush_i;
  assign ready_o     = ready_i;
  assign exception_o = exception_i && data_valid_i;

  rvc_parcel_decode #(.FETCH_WIDTH(FETCH_WIDTH)) u_decode (
    .data_valid_i      (data_valid_i),
    .exception_i       (exception_i),
    .data_i            (data_i),
    .addr_i            (addr_i),
    .start_i           (start),
    .cont_i            (cont),
    .upper_q_i         (upper_q),
    .upper_addr_i      (upper_addr_q),
    .instr_o           (instr_o),
    .addr_o            (addr_o),
    .valid_o           (valid_o),
    .straddle_o        (straddle),
    .straddle_parcel_o (straddle_parcel),
    .straddle_addr_o   (straddle_addr)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      has_upper    <= 1'b0;
      upper_q      <= '0;
      upper_addr_q <= '0;
    end else if (flush_i || replay_i) begin
      has_upper <= 1'b0;
    end else if (accept) begin
      has_upper <= straddle;
      if (straddle) begin
        upper_q      <= straddle_parcel;
        upper_addr_q <= straddle_addr;
      end
    end
  end

endmodule

// File: tb/tb_fetch_realign.sv
// Directed scoreboard bench for fetch_realign with a 64-bit packet (four parcels).
module tb_fetch_realign;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             flush_i = 1'b0;
  logic             replay_i = 1'b0;
  logic             data_valid_i = 1'b0;
  logic [63:0]      data_i = '0;
  logic [63:0]      addr_i = '0;
  logic             exception_i = 1'b0;
  logic             ready_i = 1'b1;
  logic             ready_o;
  logic [3:0][31:0] instr_o;
  logic [3:0][63:0] addr_o;
  logic [3:0]       valid_o;
  logic             exception_o;

  fetch_realign #(.FETCH_WIDTH(64)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .replay_i     (replay_i),
    .data_valid_i (data_valid_i),
    .data_i       (data_i),
    .addr_i       (addr_i),
    .exception_i  (exception_i),
    .ready_i      (ready_i),
    .ready_o      (ready_o),
    .instr_o      (instr_o),
    .addr_o       (addr_o),
    .valid_o      (valid_o),
    .exception_o  (exception_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic             idle;
    logic [3:0]       v;
    logic [3:0][31:0] ins;
    logic [3:0][63:0] ad;
    logic             ex;
    logic             rdy;
    logic             hu;
  } exp_t;

  exp_t q[$];
  exp_t e;
  exp_t m;
  int   compared = 0;
  int   failed   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic clr(input logic hu);
    e    = '0;
    e.hu = hu;
  endtask

  task automatic slot(input int j, input logic [31:0] i, input logic [63:0] a);
    e.v[j]   = 1'b1;
    e.ins[j] = i;
    e.ad[j]  = a;
  endtask

  task automatic cycle(input logic dv, input logic [63:0] d, input logic [63:0] a,
                       input logic ex, input logic rdy, input logic rep, input logic fl,
                       input logic rst_pulse);
    @(posedge clk_i);
    #1;
    if (rst_pulse) begin
      rst_ni = 1'b0;
      #1;
      rst_ni = 1'b1;
    end
    data_valid_i = dv;
    data_i       = d;
    addr_i       = a;
    exception_i  = ex;
    ready_i      = rdy;
    replay_i     = rep;
    flush_i      = fl;
    e.idle       = !dv;
    e.ex         = ex & dv;
    e.rdy        = rdy;
    q.push_back(e);
  endtask

  task automatic idle(input logic hu, input logic fl);
    clr(hu);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, fl, 1'b0);
  endtask

  // Packet 0x1000 with three compressed parcels and a 32-bit opcode in the last parcel.
  task automatic straddle_pkt(input logic hu);
    clr(hu);
    slot(0, 32'h1, 64'h1000);
    slot(1, 32'h1, 64'h1002);
    slot(2, 32'h1, 64'h1004);
    cycle(1'b1, 64'h0113_0001_0001_0001, 64'h1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: one expectation per driven cycle, checked mid-cycle.
  initial begin
    forever begin
      @(negedge clk_i);
      if (q.size() != 0) begin
        m = q.pop_front();
        chk("valid_o", {60'b0, valid_o}, {60'b0, m.v});
        for (int j = 0; j < 4; j++) begin
          if (m.idle || m.v[j]) begin
            chk($sformatf("instr_o[%0d]", j), {32'b0, instr_o[j]}, {32'b0, m.ins[j]});
            chk($sformatf("addr_o[%0d]", j), addr_o[j], m.ad[j]);
          end
        end
        chk("exception_o", {63'b0, exception_o}, {63'b0, m.ex});
        chk("ready_o", {63'b0, ready_o}, {63'b0, m.rdy});
        chk("has_upper", {63'b0, dut.has_upper}, {63'b0, m.hu});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    idle(1'b0, 1'b0);

    // Aligned pair of 32-bit instructions
    clr(1'b0);
    slot(0, 32'h00500113, 64'h1000);
    slot(1, 32'h00A00093, 64'h1004);
    cycle(1'b1, 64'h00A00093_00500113, 64'h1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Four compressed
    clr(1'b0);
    for (int j = 0; j < 4; j++) slot(j, 32'h1, 64'h1000 + 64'(2 * j));
    cycle(1'b1, 64'h0001_0001_0001_0001, 64'h1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Straddle then continuation
    straddle_pkt(1'b0);
    clr(1'b1);
    slot(0, 32'h00500113, 64'h1006);
    slot(1, 32'h1, 64'h100A);
    slot(2, 32'h1, 64'h100C);
    slot(3, 32'h1, 64'h100E);
    cycle(1'b1, 64'h0001_0001_0001_0050, 64'h1008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Branch target at parcel 1 discards the stored half
    straddle_pkt(1'b0);
    clr(1'b1);
    slot(0, 32'h1, 64'h100A);
    slot(1, 32'h1, 64'h100C);
    slot(2, 32'h1, 64'h100E);
    cycle(1'b1, 64'h0001_0001_0001_0050, 64'h100A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);

    // Replay clears straddle; refetch of lone last parcel re-stores it; flush clears
    straddle_pkt(1'b0);
    clr(1'b1);
    slot(0, 32'h00500113, 64'h1006);
    slot(1, 32'h1, 64'h100A);
    slot(2, 32'h1, 64'h100C);
    slot(3, 32'h1, 64'h100E);
    cycle(1'b1, 64'h0001_0001_0001_0050, 64'h1008, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    clr(1'b0);
    cycle(1'b1, 64'h0113_0001_0001_0001, 64'h1006, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b0, 1'b0);

    // Exception held with ready low for two cycles
    straddle_pkt(1'b0);
    for (int k = 0; k < 3; k++) begin
      clr(1'b1);
      slot(0, 32'h0, 64'h2004);
      cycle(1'b1, 64'h0113_0001_0001_0001, 64'h2004, 1'b1, (k == 2), 1'b0, 1'b0, 1'b0);
    end
    idle(1'b0, 1'b0);

    // Asynchronous reset between packets drops the pending half
    straddle_pkt(1'b0);
    idle(1'b1, 1'b0);
    clr(1'b0);
    slot(0, 32'h00000050, 64'h1008);
    slot(1, 32'h1, 64'h100A);
    slot(2, 32'h1, 64'h100C);
    slot(3, 32'h1, 64'h100E);
    cycle(1'b1, 64'h0001_0001_0001_0050, 64'h1008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0);

    repeat (3) @(posedge clk_i);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/fetch_realign.md
Name: fetch_realign

Overview:
- Producer-side partner of the frontend instruction queue: turns one aligned I$ fetch packet per cycle into up to INSTR_PER_FETCH instruction slots.
- Each slot carries an instruction, its PC and a valid bit, in the format the queue consumes.
- Handles mixed 16/32-bit (RVC) instructions, branch-target entry offsets and exceptions.
- Carries the lower half of a 32-bit instruction that straddles a packet boundary across packets.
- Sits between the I$ response path and the instruction queue.

Parameters:
- FETCH_WIDTH, 64: fetch packet width in bits. Only 32 and 64 are supported.
- INSTR_PER_FETCH, FETCH_WIDTH/16: number of 16-bit parcels per packet, which equals the maximum number of output slots. Derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  frontend flush; clears straddle state
- replay_i  in  1  queue replay_o; packet rejected, fetch restarts; clears straddle state
- data_valid_i  in  1  fetch packet valid
- data_i  in  FETCH_WIDTH  packet data; parcel k = data_i[16k+15:16k]
- addr_i  in  64  PC of first useful parcel; bits [log2(FETCH_WIDTH/8)-1:1] give start parcel s
- exception_i  in  1  packet carries a page fault
- ready_i  in  1  queue ready_o
- ready_o  out  1  packet accepted; = ready_i
- instr_o  out  INSTR_PER_FETCH x 32  instruction per slot; compressed instructions are zero-extended
- addr_o  out  INSTR_PER_FETCH x 64  PC per slot
- valid_o  out  INSTR_PER_FETCH  slot valid; always contiguous from bit 0
- exception_o  out  1  = exception_i & data_valid_i

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous active-low.
- State registers: has_upper (1 bit), upper_q (16 bits), upper_addr_q (64 bits; PC of the straddling instruction).
- Reset values: all state registers 0. Outputs are combinational from inputs and state. With data_valid_i=0: valid_o=0, instr_o=0, addr_o=0.
- Latency: 0 cycles, combinational input to output. State updates only on accept = data_valid_i & ready_i & ~replay_i & ~flush_i.
- Continuity check: cont = has_upper & (s==0) & (addr_i == upper_addr_q+2).
  - If has_upper is set but cont is 0, the stored half is discarded. No slot is emitted for it.
- Parsing: walk parcels p from s up to INSTR_PER_FETCH-1, filling slots in order from 0.
  - If cont: slot0 = {parcel0, upper_q}, addr = upper_addr_q, walk continues at p=1.
  - If parcel[1:0] != 2'b11: 16-bit instruction, {16'b0, parcel}, consumes 1 parcel.
  - Else, if p < last: 32-bit instruction {parcel p+1, parcel p}, consumes 2 parcels.
  - Else (p = last): straddle. No slot is emitted. On accept: has_upper<=1, upper_q<=parcel, upper_addr_q<=slot PC.
  - Slot PC = {addr_i[63:log2(FETCH_WIDTH/8)], p, 1'b0}, i.e. the packet base plus 2*p.
- Straddle clear: on accept without a new straddle, has_upper<=0.
- Exception packet:
  - Emit exactly slot0 valid, instr 0, addr = addr_i. No parsing.
  - On accept, has_upper<=0. The queue marks the entry ex.
- Priority, highest first: flush_i, replay_i, accept. Both flush_i and replay_i clear has_upper.
  - Safe on replay: replay restarts fetch at an instruction start, and the straddle start address is re-fetched at parcel offset last.
- ready_i low: outputs still driven; state holds.
- Reset asserted mid-packet: state is cleared asynchronously. The next packet is parsed with no straddle.

Decomposition:
- Package additions to ariane_pkg: FETCH_WIDTH and INSTR_PER_FETCH (shared with the instruction queue), and an is_rvc(parcel) function.
- One sub-module, rvc_parcel_decode: a purely combinational parcel walker producing slot instr/addr/valid plus straddle outputs. The top level holds the state registers and the accept logic.

Test Plan:
- Aligned all-32-bit: addr 0x1000, data 0x00A00093_00500113 (64-bit packet) -> valid_o=0011; slot0 0x00500113 @0x1000; slot1 0x00A00093 @0x1004; has_upper=0.
- Four compressed: data 0x0001_0001_0001_0001 -> valid_o=1111; addrs 0x1000/2/4/6; instr 0x00000001 each.
- Straddle: packet@0x1000 with parcels {0x0001, 0x0001, 0x0001, 0x0113} -> valid_o=0111, upper stored @0x1006. Next packet@0x1008, parcel0=0x0050 -> slot0 0x00500113 @0x1006.
- Branch-target offset: addr 0x100A (s=1) with has_upper=1 -> upper discarded; first slot @0x100A; no slot @0x1006.
- Replay/flush: straddle pending, then replay_i=1 during next packet -> has_upper=0. Re-fetch at 0x1006 (s=3, lone parcel) -> re-stores upper; no slot emitted.
- Exception with ready_i low for 2 cycles: exception_i=1, addr 0x2004 -> valid_o=0001, instr 0, exception_o=1; state held until ready_i=1, then has_upper=0.
